pergate_gatefn_sequencer: RTL

- Initiator/collector for a per-gate gate-function evaluator (nVals parallel add-or-mul lanes with an en / ready / ready_pulse handshake).
- Accepts operand vectors from an upstream valid/ready stream and issues one en pulse per request, holding operands stable until the evaluator reports completion.
- Captures the evaluator's results on ready_pulse and presents them to a downstream valid/ready stream, with a completion watchdog and an op counter.
- Sits between the sumcheck-round operand fetch logic and the per-gate evaluator.

---
 rtl/pergate_seq_pkg.sv | 18 +
 rtl/pergate_seq_watchdog.sv | 31 +++
 rtl/pergate_gatefn_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pergate_seq_pkg.sv
// Shared types and helpers for the per-gate gate-function sequencer.
package pergate_seq_pkg;

  // Field element width, matching the field arithmetic (Mersenne-61) datapath.
  localparam int F_NBITS = 61;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } seq_state_t;

  function automatic int wd_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/pergate_seq_watchdog.sv
// Completion watchdog: cleared on issue, counts while waiting, flags expiry at TIMEOUT-1.
module pergate_seq_watchdog
  import pergate_seq_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int W = wd_width(TIMEOUT);

  logic [W-1:0] r_count;

  assign o_expire = i_run && (r_count == W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pergate_gatefn_sequencer.sv
// Issues one evaluator start per upstream request, holds operands, and hands
// the captured (or watchdog-aborted) result to the downstream stream.
module pergate_gatefn_sequencer
  import pergate_seq_pkg::*;
#(
  parameter int nVals    = 4,
  parameter int TIMEOUT  = 64,
  parameter int CNT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_mux_sel,
  input  logic [nVals*F_NBITS-1:0]   req_in0,
  input  logic [nVals*F_NBITS-1:0]   req_in1,
  output logic                       fn_en,
  output logic                       fn_mux_sel,
  output logic [nVals*F_NBITS-1:0]   fn_in0,
  output logic [nVals*F_NBITS-1:0]   fn_in1,
  input  logic                       fn_ready,
  input  logic                       fn_ready_pulse,
  input  logic [nVals*F_NBITS-1:0]   fn_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [nVals*F_NBITS-1:0]   res_out,
  output logic                       res_err,
  output logic                       err_sticky,
  output logic [CNT_BITS-1:0]        op_count
);

  localparam int VW = nVals * F_NBITS;

  seq_state_t          r_state, w_next;
  logic                r_fn_mux_sel;
  logic [VW-1:0]       r_fn_in0, r_fn_in1, r_res_out;
  logic                r_res_err, r_err_sticky;
  logic [CNT_BITS-1:0] r_op_count;
  logic                w_accept, w_capture, w_abort, w_handoff;
  logic                w_wd_clear, w_wd_run, w_wd_expire;

  pergate_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wd_clear),
    .i_run    (w_wd_run),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    fn_en      = 1'b0;
    w_wd_clear = 1'b0;
    w_wd_run   = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_abort    = 1'b0;
    w_handoff  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = fn_ready;
        if (req_valid && fn_ready) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Any completion pulse seen here belongs to an earlier operation.
        fn_en      = 1'b1;
        w_wd_clear = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        w_wd_run = 1'b1;
        if (fn_ready_pulse) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end else if (w_wd_expire) begin
          w_abort = 1'b1;
          w_next  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_handoff = 1'b1;
          req_ready = fn_ready;
          if (req_valid && fn_ready) begin
            w_accept = 1'b1;
            w_next   = S_ISSUE;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset as well because the reset values are externally visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fn_mux_sel <= 1'b0;
      r_fn_in0     <= '0;
      r_fn_in1     <= '0;
      r_res_out    <= '0;
      r_res_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_fn_mux_sel <= req_mux_sel;
        r_fn_in0     <= req_in0;
        r_fn_in1     <= req_in1;
      end
      if (w_capture) begin
        r_res_out <= fn_out;
        r_res_err <= 1'b0;
      end else if (w_abort) begin
        r_res_out    <= '0;
        r_res_err    <= 1'b1;
        r_err_sticky <= 1'b1;
      end
      if (w_handoff) r_op_count <= r_op_count + 1'b1;
    end
  end

  assign res_valid  = (r_state == S_HOLD);
  assign fn_mux_sel = r_fn_mux_sel;
  assign fn_in0     = r_fn_in0;
  assign fn_in1     = r_fn_in1;
  assign res_out    = r_res_out;
  assign res_err    = r_res_err;
  assign err_sticky = r_err_sticky;
  assign op_count   = r_op_count;

endmodule
